// File: rtl/pc_fetch_controller.sv
// Instruction fetch controller: one outstanding memory request, a single-entry
// instruction buffer, and redirect handling that drains in-flight responses.
module pc_fetch_controller #(
    parameter int unsigned          PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    output logic                instr_valid,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] instr_pc,
    input  logic                instr_ready,
    output logic [PC_WIDTH-1:0] fetch_pc,
    output logic                misalign_err,
    output logic [7:0]          discard_cnt
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, VALID} state_t;

    state_t                r_state, w_state_nxt;
    logic [PC_WIDTH-1:0]   r_fetch_pc, w_fetch_pc_nxt;
    logic [PC_WIDTH-1:0]   r_req_addr;
    logic [31:0]           r_instr;
    logic [PC_WIDTH-1:0]   r_instr_pc;
    logic                  r_misalign;
    logic [7:0]            r_discard_cnt;
    logic                  w_capture;
    logic                  w_discard;
    logic                  w_enter_fetch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_fetch_pc    <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_misalign    <= 1'b0;
            r_discard_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            if (w_enter_fetch)
                r_req_addr <= w_fetch_pc_nxt;
            if (w_capture) begin
                r_instr    <= imem_rsp_data;
                r_instr_pc <= r_req_addr;
            end
            if (redirect_valid && (redirect_target[1:0] != 2'b00))
                r_misalign <= 1'b1;
            if (w_discard && (r_discard_cnt != '1))
                r_discard_cnt <= r_discard_cnt + 8'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  w_state_nxt = FETCH;
            FETCH: begin
                if (redirect_valid)
                    w_state_nxt = imem_rsp_valid ? FETCH : DRAIN;
                else if (imem_rsp_valid)
                    w_state_nxt = VALID;
            end
            DRAIN: if (imem_rsp_valid) w_state_nxt = FETCH;
            VALID: if (redirect_valid || instr_ready) w_state_nxt = FETCH;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (r_state == FETCH) || (r_state == DRAIN);
        instr_valid = (r_state == VALID) && !redirect_valid;
        w_capture   = (r_state == FETCH) && imem_rsp_valid && !redirect_valid;
        w_discard   = imem_rsp_valid &&
                      (((r_state == FETCH) && redirect_valid) || (r_state == DRAIN));
        if (redirect_valid)
            w_fetch_pc_nxt = {redirect_target[PC_WIDTH-1:2], 2'b00};
        else if (w_capture)
            w_fetch_pc_nxt = r_req_addr + PC_WIDTH'(4);
        else
            w_fetch_pc_nxt = r_fetch_pc;
        // FETCH->FETCH is a fresh request only when the old response was discarded
        w_enter_fetch = (w_state_nxt == FETCH) && ((r_state != FETCH) || w_discard);
    end

    assign imem_addr    = r_req_addr;
    assign instr        = r_instr;
    assign instr_pc     = r_instr_pc;
    assign fetch_pc     = r_fetch_pc;
    assign misalign_err = r_misalign;
    assign discard_cnt  = r_discard_cnt;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller: inputs change and outputs are
// sampled 1ns after each rising edge.
module tb_pc_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic [15:0] fetch_pc;
    logic        misalign_err;
    logic [7:0]  discard_cnt;

    int checks = 0;
    int fails  = 0;

    pc_fetch_controller #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fetch_pc(fetch_pc),
        .misalign_err(misalign_err), .discard_cnt(discard_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle memory response carrying a word derived from addr.
    task automatic respond(input logic [15:0] addr);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = {16'hC0DE, addr};
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; instr_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // From IDLE/FETCH-pending, step through one fetch with ready=1 (stimulus only).
    task automatic fetch_one(input logic [15:0] addr);
        instr_ready = 1'b1;
        respond(addr);
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b want 0", imem_req); end
        checks++; if (fetch_pc !== 16'h0000) begin fails++; $display("FAIL rst_fetch_pc got %h want 0000", fetch_pc); end
        checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 16'h0) begin fails++;
            $display("FAIL rst_buffer got v=%b i=%h pc=%h want 0/0/0", instr_valid, instr, instr_pc); end
        checks++; if (misalign_err !== 1'b0 || discard_cnt !== 8'd0) begin fails++;
            $display("FAIL rst_flags got mis=%b cnt=%0d want 0/0", misalign_err, discard_cnt); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin fails++;
            $display("FAIL first_req got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        logic [15:0] a;
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 16'(4 * k);
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin fails++;
                $display("FAIL seq_req%0d got req=%b addr=%h want 1/%h", k, imem_req, imem_addr, a); end
            respond(a);
            checks++; if (instr_valid !== 1'b1 || instr_pc !== a || instr !== {16'hC0DE, a}) begin fails++;
                $display("FAIL seq_valid%0d got v=%b pc=%h i=%h want 1/%h/%h", k, instr_valid, instr_pc, instr, a, {16'hC0DE, a}); end
            checks++; if (fetch_pc !== a + 16'd4 || imem_req !== 1'b0) begin fails++;
                $display("FAIL seq_fpc%0d got fpc=%h req=%b want %h/0", k, fetch_pc, imem_req, a + 16'd4); end
            tick();
            checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== a + 16'd4) begin fails++;
                $display("FAIL seq_pulse%0d got v=%b req=%b addr=%h want 0/1/%h", k, instr_valid, imem_req, imem_addr, a + 16'd4); end
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_stall();
        respond(16'h000C);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) imem_rsp_valid = 1'b1;
            tick();
            imem_rsp_valid = 1'b0;
            checks++; if (instr_valid !== 1'b1 || instr !== 32'hC0DE000C || instr_pc !== 16'h000C) begin fails++;
                $display("FAIL stall_hold%0d got v=%b i=%h pc=%h want 1/c0de000c/000c", c, instr_valid, instr, instr_pc); end
            checks++; if (imem_req !== 1'b0 || fetch_pc !== 16'h0010 || discard_cnt !== 8'd0) begin fails++;
                $display("FAIL stall_ctl%0d got req=%b fpc=%h cnt=%0d want 0/0010/0", c, imem_req, fetch_pc, discard_cnt); end
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin fails++;
            $display("FAIL stall_release got req=%b addr=%h want 1/0010", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        tick();
        fetch_one(16'h0000);
        fetch_one(16'h0004);
        redirect_valid = 1'b1; redirect_target = 16'h0100;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0008 || fetch_pc !== 16'h0100) begin fails++;
            $display("FAIL drain_hold got req=%b addr=%h fpc=%h want 1/0008/0100", imem_req, imem_addr, fetch_pc); end
        tick();
        checks++; if (imem_addr !== 16'h0008 || instr_valid !== 1'b0) begin fails++;
            $display("FAIL drain_hold2 got addr=%h v=%b want 0008/0", imem_addr, instr_valid); end
        respond(16'h0008);
        checks++; if (discard_cnt !== 8'd1 || imem_req !== 1'b1 || imem_addr !== 16'h0100 || instr_valid !== 1'b0) begin fails++;
            $display("FAIL drain_done got cnt=%0d req=%b addr=%h v=%b want 1/1/0100/0", discard_cnt, imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_redirect_valid();
        respond(16'h0100);
        redirect_valid = 1'b1; redirect_target = 16'h0200; instr_ready = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rv_comb got v=%b want 0", instr_valid); end
        tick();
        redirect_valid = 1'b0; instr_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200 || fetch_pc !== 16'h0200 || instr_pc !== 16'h0100) begin fails++;
            $display("FAIL rv_next got req=%b addr=%h fpc=%h pc=%h want 1/0200/0200/0100", imem_req, imem_addr, fetch_pc, instr_pc); end
        // redirect coincident with a response in FETCH
        redirect_valid = 1'b1; redirect_target = 16'h0300;
        respond(16'h0200);
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 16'h0300 || discard_cnt !== 8'd2 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin fails++;
            $display("FAIL rf_same got addr=%h cnt=%0d v=%b req=%b want 0300/2/0/1", imem_addr, discard_cnt, instr_valid, imem_req); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 16'hFFFC;
        respond(16'h0300);
        redirect_valid = 1'b0;
        respond(16'hFFFC);
        checks++; if (fetch_pc !== 16'h0000 || instr_pc !== 16'hFFFC || misalign_err !== 1'b0) begin fails++;
            $display("FAIL wrap got fpc=%h pc=%h mis=%b want 0000/fffc/0", fetch_pc, instr_pc, misalign_err); end
        redirect_valid = 1'b1; redirect_target = 16'h0043;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fetch_pc !== 16'h0040 || imem_addr !== 16'h0040 || misalign_err !== 1'b1) begin fails++;
            $display("FAIL misalign got fpc=%h addr=%h mis=%b want 0040/0040/1", fetch_pc, imem_addr, misalign_err); end
        redirect_valid = 1'b1; redirect_target = 16'h0080;
        tick();
        redirect_valid = 1'b0;
        checks++; if (misalign_err !== 1'b1 || fetch_pc !== 16'h0080) begin fails++;
            $display("FAIL mis_sticky got mis=%b fpc=%h want 1/0080", misalign_err, fetch_pc); end
    endtask

    task automatic test_reset_drain();
        do_reset();
        tick();
        for (int i = 1; i <= 5; i++) begin
            redirect_valid = 1'b1; redirect_target = 16'(32 * i);
            respond(imem_addr);
        end
        redirect_valid = 1'b1; redirect_target = 16'h0400;
        tick();
        redirect_target = 16'h0480;
        tick();
        redirect_valid = 1'b0;
        checks++; if (discard_cnt !== 8'd5 || fetch_pc !== 16'h0480 || imem_addr !== 16'h00A0) begin fails++;
            $display("FAIL latest_wins got cnt=%0d fpc=%h addr=%h want 5/0480/00a0", discard_cnt, fetch_pc, imem_addr); end
        rst = 1'b1; imem_rsp_valid = 1'b1;
        tick();
        rst = 1'b0; imem_rsp_valid = 1'b0;
        checks++; if (imem_req !== 1'b0 || fetch_pc !== 16'h0000 || discard_cnt !== 8'd0) begin fails++;
            $display("FAIL rst_drain got req=%b fpc=%h cnt=%0d want 0/0000/0", imem_req, fetch_pc, discard_cnt); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin fails++;
            $display("FAIL rst_refetch got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) begin
            redirect_valid = 1'b1; redirect_target = 16'h0010;
            respond(imem_addr);
        end
        redirect_valid = 1'b0;
        checks++; if (discard_cnt !== 8'd255) begin fails++; $display("FAIL saturate got %0d want 255", discard_cnt); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drain();
        test_redirect_valid();
        test_wrap();
        test_reset_drain();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule

// File: doc/pc_fetch_controller.md
PC_FETCH_CONTROLLER -- requirements
Module: pc_fetch_controller

Interface
REQ-001 The module SHALL have a parameter PC_WIDTH, default 16: width of all PC/address signals.
REQ-002 The module SHALL have a parameter RESET_PC, default 0: fetch address loaded on reset.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 redirect_valid  in  1  branch/jump redirect request.
REQ-007 redirect_target  in  PC_WIDTH  redirect destination.
REQ-008 imem_req  out  1  instruction-memory request.
REQ-009 imem_addr  out  PC_WIDTH  request address.
REQ-010 imem_rsp_valid  in  1  memory response strobe, one cycle per request.
REQ-011 imem_rsp_data  in  32  response instruction word.
REQ-012 instr_valid  out  1  buffered instruction available downstream.
REQ-013 instr  out  32  buffered instruction.
REQ-014 instr_pc  out  PC_WIDTH  address of the buffered instruction.
REQ-015 instr_ready  in  1  downstream accepts instruction.
REQ-016 fetch_pc  out  PC_WIDTH  next address to be fetched.
REQ-017 misalign_err  out  1  sticky flag: a redirect target had bits [1:0] nonzero.
REQ-018 discard_cnt  out  8  count of discarded memory responses, saturating at 255.

Function
REQ-019 The FSM SHALL have four states: IDLE, FETCH, DRAIN, VALID.
REQ-020 IDLE SHALL move to FETCH unconditionally after one cycle, with imem_req=0.
REQ-021 On entry to FETCH, the block SHALL latch req_addr=fetch_pc, so that imem_addr=req_addr while imem_req=1.
REQ-022 imem_req SHALL be 1 exactly in FETCH and DRAIN.
REQ-023 imem_req and imem_addr SHALL be held stable until imem_rsp_valid is seen.
REQ-024 Only one request SHALL be outstanding at a time.
REQ-025 In FETCH, imem_rsp_valid without redirect SHALL capture instr=imem_rsp_data and instr_pc=req_addr, set fetch_pc=req_addr+4, and go to VALID.
REQ-026 The +4 addition SHALL wrap modulo 2^PC_WIDTH, with no carry out.
REQ-027 In VALID, instr_valid SHALL equal !redirect_valid, combinationally.
REQ-028 In VALID, instr_valid&&instr_ready SHALL move the FSM to FETCH on the next cycle.
REQ-029 In VALID without ready, instr, instr_pc and instr_valid SHALL be held unchanged.
REQ-030 In FETCH, DRAIN or VALID, redirect_valid SHALL set fetch_pc={redirect_target[PC_WIDTH-1:2],2'b00}.
REQ-031 If redirect_target[1:0]!=0, misalign_err SHALL be set; it clears only on rst.
REQ-032 Redirect in FETCH without a same-cycle response SHALL move the FSM to DRAIN, keeping the request held on the old address.
REQ-033 Redirect in FETCH with a same-cycle response SHALL discard that response and move the FSM to FETCH with the new fetch_pc.
REQ-034 In DRAIN, imem_rsp_valid SHALL discard the response and move the FSM to FETCH.
REQ-035 A further redirect in DRAIN SHALL overwrite fetch_pc, latest wins.
REQ-036 A redirect in DRAIN coincident with a response SHALL leave the FSM in FETCH at the newest target.
REQ-037 Redirect in VALID SHALL flush the buffer and move the FSM to FETCH; a same-cycle ready is not a transfer.
REQ-038 Redirect in IDLE SHALL update fetch_pc; the FSM still goes to FETCH.
REQ-039 Each discarded response SHALL increment discard_cnt by 1, holding at 255.
REQ-040 imem_rsp_valid in IDLE or VALID is a protocol error and SHALL be ignored, with no state change.

Reset
REQ-041 rst=1 SHALL force, on the next edge: state=IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, misalign_err=0, discard_cnt=0.
REQ-042 rst SHALL take priority over all inputs, including mid-request.
REQ-043 A response arriving after reset from a pre-reset request is the memory's responsibility to suppress.

Verification
REQ-044 Reset, then response latency 2 cycles and instr_ready=1 -> imem_addr 0x0000, 0x0004, 0x0008 in turn; instr_pc matches; instr_valid pulses once per fetch.
REQ-045 Hold instr_ready=0 for 5 cycles in VALID -> instr/instr_pc stable, imem_req=0, fetch_pc=instr_pc+4.
REQ-046 Redirect to 0x0100 while the request to 0x0008 is pending -> imem_addr stays 0x0008 until response; response discarded; discard_cnt=1; next request at 0x0100.
REQ-047 Redirect to 0x0200 in VALID with instr_ready=1 in the same cycle -> instr_valid=0 that cycle; next imem_addr=0x0200; no transfer counted.
REQ-048 fetch_pc=0xFFFC, response received -> fetch_pc becomes 0x0000; redirect target 0x0043 -> fetch_pc=0x0040 and misalign_err=1.
REQ-049 Assert rst during DRAIN, with discard_cnt=5 -> next cycle IDLE, imem_req=0, fetch_pc=RESET_PC, discard_cnt=0.
